lights_sequencer: RTL and testbench

LIGHTS_SEQUENCER -- requirements
Module: lights_sequencer

---
 rtl/lights_pkg.sv | 72 +++++++
 rtl/sync_edge_detect.sv | 37 +++
 rtl/lights_sequencer.sv | 107 ++++++++++
 tb/tb_lights_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lights_pkg.sv
// Shared definitions for the turn-signal lights sequencer: FSM states,
// request classes, lamp patterns and the decode/lamp lookup helpers.
package lights_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    L1   = 3'd1,
    L2   = 3'd2,
    L3   = 3'd3,
    R1   = 3'd4,
    R2   = 3'd5,
    R3   = 3'd6,
    LR3  = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    REQ_NONE  = 2'd0,
    REQ_LEFT  = 2'd1,
    REQ_RIGHT = 2'd2,
    REQ_HAZ   = 2'd3
  } req_t;

  // Lamp bit0 is the innermost lamp, so a sweep fills from the inside out.
  localparam logic [2:0] LAMPS_OFF = 3'b000;
  localparam logic [2:0] LAMPS_ONE = 3'b001;
  localparam logic [2:0] LAMPS_TWO = 3'b011;
  localparam logic [2:0] LAMPS_ALL = 3'b111;

  localparam int REQ_SYNC_STAGES = 2;

  // Both turn levers at once is treated the same as the hazard switch.
  function automatic req_t decode_req(input logic hazard,
                                      input logic left,
                                      input logic right);
    req_t req;
    if (hazard || (left && right)) begin
      req = REQ_HAZ;
    end else if (left) begin
      req = REQ_LEFT;
    end else if (right) begin
      req = REQ_RIGHT;
    end else begin
      req = REQ_NONE;
    end
    return req;
  endfunction

  function automatic logic [2:0] left_lamps(input state_t state);
    logic [2:0] lamps;
    case (state)
      L1:      lamps = LAMPS_ONE;
      L2:      lamps = LAMPS_TWO;
      L3:      lamps = LAMPS_ALL;
      LR3:     lamps = LAMPS_ALL;
      default: lamps = LAMPS_OFF;
    endcase
    return lamps;
  endfunction

  function automatic logic [2:0] right_lamps(input state_t state);
    logic [2:0] lamps;
    case (state)
      R1:      lamps = LAMPS_ONE;
      R2:      lamps = LAMPS_TWO;
      R3:      lamps = LAMPS_ALL;
      LR3:     lamps = LAMPS_ALL;
      default: lamps = LAMPS_OFF;
    endcase
    return lamps;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes a slow asynchronous square wave into the clk domain and
// emits a one-cycle pulse for each rising edge.
module sync_edge_detect #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic [DEPTH-1:0] sync_q;
  logic             history_q;
  logic [DEPTH-1:0] valid_q;
  logic             armed_q;

  // The armed flag only sets once a genuine low has travelled through the
  // chain, so an input already high at reset release cannot fake an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= '0;
      history_q <= 1'b0;
      valid_q   <= '0;
      armed_q   <= 1'b0;
    end else begin
      sync_q    <= {sync_q[DEPTH-2:0], async_in};
      history_q <= sync_q[DEPTH-1];
      valid_q   <= {valid_q[DEPTH-2:0], 1'b1};
      if (valid_q[DEPTH-1] && !sync_q[DEPTH-1]) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign rise = sync_q[DEPTH-1] & ~history_q & armed_q;

endmodule

// File: rtl/lights_sequencer.sv
// Turn-signal / hazard lamp sequencer: advances one state per rising edge
// of the divided lights clock and drives registered lamp outputs.
module lights_sequencer
  import lights_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       step_clk,
  input  logic       left,
  input  logic       right,
  input  logic       hazard,
  output logic [2:0] la,
  output logic [2:0] ra,
  output logic       busy
);

  logic   step;
  logic   [2:0] req_meta;
  logic   [2:0] req_sync;
  req_t   req;
  state_t state;
  state_t next_state;

  sync_edge_detect #(
    .DEPTH(SYNC_STAGES)
  ) u_step_sync (
    .clk     (clk),
    .reset   (reset),
    .async_in(step_clk),
    .rise    (step)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_meta <= '0;
      req_sync <= '0;
    end else begin
      req_meta <= {hazard, left, right};
      req_sync <= req_meta;
    end
  end

  assign req = decode_req(req_sync[2], req_sync[1], req_sync[0]);

  // Every branch waits for step, except unknown encodings which bail out to IDLE at once.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (step) begin
          case (req)
            REQ_HAZ:   next_state = LR3;
            REQ_LEFT:  next_state = L1;
            REQ_RIGHT: next_state = R1;
            default:   next_state = IDLE;
          endcase
        end
      end
      L1, L2: begin
        if (step) begin
          if (req == REQ_HAZ) begin
            next_state = LR3;
          end else if (req == REQ_LEFT) begin
            next_state = (state == L1) ? L2 : L3;
          end else begin
            next_state = IDLE;
          end
        end
      end
      R1, R2: begin
        if (step) begin
          if (req == REQ_HAZ) begin
            next_state = LR3;
          end else if (req == REQ_RIGHT) begin
            next_state = (state == R1) ? R2 : R3;
          end else begin
            next_state = IDLE;
          end
        end
      end
      L3, R3, LR3: begin
        if (step) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Lamps are registered from next_state so they move on the same edge as the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      la    <= LAMPS_OFF;
      ra    <= LAMPS_OFF;
      busy  <= 1'b0;
    end else begin
      state <= next_state;
      la    <= left_lamps(next_state);
      ra    <= right_lamps(next_state);
      busy  <= (next_state != IDLE);
    end
  end

endmodule

// File: tb/tb_lights_sequencer.sv
// Self-checking bench for lights_sequencer: expected lamp states are queued
// as each step is driven and compared once the sequencer should respond.
module tb_lights_sequencer;

  typedef struct {
    string      name;
    logic [2:0] la;
    logic [2:0] ra;
    logic       busy;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       step_clk;
  logic       left;
  logic       right;
  logic       hazard;
  logic [2:0] la;
  logic [2:0] ra;
  logic       busy;

  int   vectors;
  int   miscompares;
  exp_t sb[$];

  lights_sequencer #(
    .SYNC_STAGES(2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .step_clk(step_clk),
    .left    (left),
    .right   (right),
    .hazard  (hazard),
    .la      (la),
    .ra      (ra),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Low for four cycles, then high; returns #1 after the third sampling edge.
  task automatic drive_step();
    @(negedge clk);
    step_clk = 1'b0;
    repeat (4) @(negedge clk);
    step_clk = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    step_clk = 1'b0;
    left     = 1'b0;
    right    = 1'b0;
    hazard   = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({la, ra, busy} !== 7'b000_000_0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got la=%b ra=%b busy=%b, expected 000/000/0", la, ra, busy);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_latency();
    exp_t e;
    left = 1'b1;
    repeat (4) @(negedge clk);
    step_clk = 1'b1;
    sb.push_back('{"latency_L1", 3'b001, 3'b000, 1'b1});
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({la, ra, busy} !== 7'b000_000_0) begin
      miscompares++;
      $display("[TB] FAIL latency_early: got la=%b ra=%b busy=%b, expected 000/000/0", la, ra, busy);
    end
    @(posedge clk);
    #1;
    e = sb.pop_front();
    vectors++;
    if ({la, ra, busy} !== {e.la, e.ra, e.busy}) begin
      miscompares++;
      $display("[TB] FAIL %s: got la=%b ra=%b busy=%b, expected %b/%b/%b", e.name, la, ra, busy, e.la, e.ra, e.busy);
    end
    left = 1'b0;
    sb.push_back('{"latency_idle", 3'b000, 3'b000, 1'b0});
    drive_step();
    e = sb.pop_front();
    vectors++;
    if ({la, ra, busy} !== {e.la, e.ra, e.busy}) begin
      miscompares++;
      $display("[TB] FAIL %s: got la=%b ra=%b busy=%b, expected %b/%b/%b", e.name, la, ra, busy, e.la, e.ra, e.busy);
    end
  endtask

  task automatic test_left_sweep();
    logic [2:0] exp_la[4];
    exp_t e;
    exp_la = '{3'b001, 3'b011, 3'b111, 3'b000};
    left   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{$sformatf("left_sweep_%0d", i), exp_la[i], 3'b000, (i != 3)});
      drive_step();
      e = sb.pop_front();
      vectors++;
      if ({la, ra, busy} !== {e.la, e.ra, e.busy}) begin
        miscompares++;
        $display("[TB] FAIL %s: got la=%b ra=%b busy=%b, expected %b/%b/%b", e.name, la, ra, busy, e.la, e.ra, e.busy);
      end
    end
    left = 1'b0;
  endtask

  task automatic test_right_drop();
    exp_t e;
    right = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) sb.push_back('{"right_R1", 3'b000, 3'b001, 1'b1});
      else        sb.push_back('{"right_drop_idle", 3'b000, 3'b000, 1'b0});
      drive_step();
      e = sb.pop_front();
      vectors++;
      if ({la, ra, busy} !== {e.la, e.ra, e.busy}) begin
        miscompares++;
        $display("[TB] FAIL %s: got la=%b ra=%b busy=%b, expected %b/%b/%b", e.name, la, ra, busy, e.la, e.ra, e.busy);
      end
      right = 1'b0;
    end
  endtask

  task automatic test_both_levers();
    exp_t e;
    left  = 1'b1;
    right = 1'b1;
    sb.push_back('{"both_LR3", 3'b111, 3'b111, 1'b1});
    sb.push_back('{"both_idle", 3'b000, 3'b000, 1'b0});
    for (int i = 0; i < 2; i++) begin
      drive_step();
      e = sb.pop_front();
      vectors++;
      if ({la, ra, busy} !== {e.la, e.ra, e.busy}) begin
        miscompares++;
        $display("[TB] FAIL %s: got la=%b ra=%b busy=%b, expected %b/%b/%b", e.name, la, ra, busy, e.la, e.ra, e.busy);
      end
    end
    left  = 1'b0;
    right = 1'b0;
  endtask

  task automatic test_hazard_in_l2();
    exp_t e;
    left = 1'b1;
    sb.push_back('{"haz_L1", 3'b001, 3'b000, 1'b1});
    sb.push_back('{"haz_L2", 3'b011, 3'b000, 1'b1});
    sb.push_back('{"haz_LR3", 3'b111, 3'b111, 1'b1});
    sb.push_back('{"haz_idle", 3'b000, 3'b000, 1'b0});
    for (int i = 0; i < 4; i++) begin
      if (i == 2) hazard = 1'b1;
      if (i == 3) begin
        hazard = 1'b0;
        left   = 1'b0;
      end
      drive_step();
      e = sb.pop_front();
      vectors++;
      if ({la, ra, busy} !== {e.la, e.ra, e.busy}) begin
        miscompares++;
        $display("[TB] FAIL %s: got la=%b ra=%b busy=%b, expected %b/%b/%b", e.name, la, ra, busy, e.la, e.ra, e.busy);
      end
    end
  endtask

  task automatic test_reset_mid_sequence();
    exp_t e;
    left = 1'b1;
    sb.push_back('{"rst_L1", 3'b001, 3'b000, 1'b1});
    sb.push_back('{"rst_L2", 3'b011, 3'b000, 1'b1});
    for (int i = 0; i < 2; i++) begin
      drive_step();
      e = sb.pop_front();
      vectors++;
      if ({la, ra, busy} !== {e.la, e.ra, e.busy}) begin
        miscompares++;
        $display("[TB] FAIL %s: got la=%b ra=%b busy=%b, expected %b/%b/%b", e.name, la, ra, busy, e.la, e.ra, e.busy);
      end
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({la, ra, busy} !== 7'b000_000_0) begin
      miscompares++;
      $display("[TB] FAIL rst_async: got la=%b ra=%b busy=%b, expected 000/000/0", la, ra, busy);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    vectors++;
    if ({la, ra, busy} !== 7'b000_000_0) begin
      miscompares++;
      $display("[TB] FAIL rst_no_step_high: got la=%b ra=%b busy=%b, expected 000/000/0", la, ra, busy);
    end
    sb.push_back('{"rst_first_step", 3'b001, 3'b000, 1'b1});
    drive_step();
    e = sb.pop_front();
    vectors++;
    if ({la, ra, busy} !== {e.la, e.ra, e.busy}) begin
      miscompares++;
      $display("[TB] FAIL %s: got la=%b ra=%b busy=%b, expected %b/%b/%b", e.name, la, ra, busy, e.la, e.ra, e.busy);
    end
    left = 1'b0;
    sb.push_back('{"rst_back_idle", 3'b000, 3'b000, 1'b0});
    drive_step();
    e = sb.pop_front();
    vectors++;
    if ({la, ra, busy} !== {e.la, e.ra, e.busy}) begin
      miscompares++;
      $display("[TB] FAIL %s: got la=%b ra=%b busy=%b, expected %b/%b/%b", e.name, la, ra, busy, e.la, e.ra, e.busy);
    end
  endtask

  task automatic test_long_high_and_glitch();
    exp_t e;
    left = 1'b1;
    sb.push_back('{"long_L1", 3'b001, 3'b000, 1'b1});
    drive_step();
    e = sb.pop_front();
    vectors++;
    if ({la, ra, busy} !== {e.la, e.ra, e.busy}) begin
      miscompares++;
      $display("[TB] FAIL %s: got la=%b ra=%b busy=%b, expected %b/%b/%b", e.name, la, ra, busy, e.la, e.ra, e.busy);
    end
    repeat (1000) @(posedge clk);
    #1;
    vectors++;
    if ({la, ra, busy} !== 7'b001_000_1) begin
      miscompares++;
      $display("[TB] FAIL long_high_one_step: got la=%b ra=%b busy=%b, expected 001/000/1", la, ra, busy);
    end
    left = 1'b0;
    sb.push_back('{"long_idle", 3'b000, 3'b000, 1'b0});
    drive_step();
    e = sb.pop_front();
    vectors++;
    if ({la, ra, busy} !== {e.la, e.ra, e.busy}) begin
      miscompares++;
      $display("[TB] FAIL %s: got la=%b ra=%b busy=%b, expected %b/%b/%b", e.name, la, ra, busy, e.la, e.ra, e.busy);
    end
    @(negedge clk);
    step_clk = 1'b0;
    repeat (5) @(negedge clk);
    left = 1'b1;
    repeat (3) @(negedge clk);
    left = 1'b0;
    repeat (5) @(negedge clk);
    vectors++;
    if ({la, ra, busy} !== 7'b000_000_0) begin
      miscompares++;
      $display("[TB] FAIL glitch_between_steps: got la=%b ra=%b busy=%b, expected 000/000/0", la, ra, busy);
    end
    sb.push_back('{"glitch_ignored", 3'b000, 3'b000, 1'b0});
    drive_step();
    e = sb.pop_front();
    vectors++;
    if ({la, ra, busy} !== {e.la, e.ra, e.busy}) begin
      miscompares++;
      $display("[TB] FAIL %s: got la=%b ra=%b busy=%b, expected %b/%b/%b", e.name, la, ra, busy, e.la, e.ra, e.busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_ra[5];
    logic [2:0] exp_la[5];
    exp_t e;
    exp_ra = '{3'b001, 3'b011, 3'b111, 3'b000, 3'b000};
    exp_la = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b001};
    right  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) begin
        right = 1'b0;
        left  = 1'b1;
      end
      sb.push_back('{$sformatf("b2b_%0d", i), exp_la[i], exp_ra[i], (i != 3)});
      drive_step();
      e = sb.pop_front();
      vectors++;
      if ({la, ra, busy} !== {e.la, e.ra, e.busy}) begin
        miscompares++;
        $display("[TB] FAIL %s: got la=%b ra=%b busy=%b, expected %b/%b/%b", e.name, la, ra, busy, e.la, e.ra, e.busy);
      end
    end
    left = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_latency();
    test_left_sweep();
    test_right_drop();
    test_both_levers();
    test_hazard_in_l2();
    test_reset_mid_sequence();
    test_long_high_and_glitch();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
